// File: rtl/dmem_ctrl_if.sv
// Split request/response data-SRAM bus between the memory-stage controller and the SRAM port.
interface dmem_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Memory-stage data-SRAM access sequencer: one load/store at a time over an addr_ok/data_ok bus,
// stalling the pipeline until the response arrives or the wait times out.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req,
    input  logic        ex_wr,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        pipe_adv,
    dmem_ctrl_if.master bus,
    output logic        stall_req,
    output logic        op_done,
    output logic [31:0] ld_data,
    output logic        err_align,
    output logic        err_timeout
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        wr_q, signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, ld_data_q, ld_data_d;
    logic [3:0]  wstrb_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        ex_aligned, accept;
    logic [3:0]  ex_wstrb;
    logic [31:0] ex_wdata_rep, rd_shift, ld_ext;

    always_comb begin
        ex_wstrb     = 4'b1111;
        ex_wdata_rep = ex_wdata;
        ex_aligned   = 1'b1;
        case (ex_size)
            2'd0: begin
                ex_wstrb     = 4'b0001 << ex_addr[1:0];
                ex_wdata_rep = {4{ex_wdata[7:0]}};
            end
            2'd1: begin
                ex_wstrb     = 4'b0011 << ex_addr[1:0];
                ex_wdata_rep = {2{ex_wdata[15:0]}};
                ex_aligned   = ~ex_addr[0];
            end
            default: ex_aligned = (ex_addr[1:0] == 2'b00);
        endcase
        if (!ex_wr) ex_wstrb = 4'b0000;
    end

    // Gated by rst so every output reads 0 while reset is held, even with ex_req high.
    assign accept = ~rst & (state_q == StIdle) & ex_req & ex_aligned;

    assign rd_shift = bus.data_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    ld_ext = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    ld_ext = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
            default: ld_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_data_d   = ld_data_q;
        err_timeout = 1'b0;
        case (state_q)
            StIdle: if (accept) state_d = StReq;
            StReq: begin
                if (bus.data_addr_ok) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.data_data_ok) begin
                    state_d = StDone;
                    if (!wr_q) ld_data_d = ld_ext;
                end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
                    err_timeout = 1'b1;
                    ld_data_d   = '0;
                    state_d     = StDone;
                end
            end
            StDone: if (pipe_adv) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            wr_q     <= ex_wr;
            signed_q <= ex_signed;
            size_q   <= (ex_size == 2'd3) ? 2'd2 : ex_size;
            addr_q   <= ex_addr;
            wstrb_q  <= ex_wstrb;
            wdata_q  <= ex_wdata_rep;
        end
    end

    assign bus.data_req   = (state_q == StReq);
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wstrb = wstrb_q;
    assign bus.data_wdata = wdata_q;

    assign stall_req = accept | (state_q == StReq) | (state_q == StWait);
    assign op_done   = (state_q == StDone);
    assign ld_data   = ld_data_q;
    assign err_align = ~rst & (state_q == StIdle) & ex_req & ~ex_aligned;
endmodule
